mp_mem_arbiter: RTL and testbench

- Four-core round-robin arbiter that shares the single request port of the shared-memory DUT between all cores.
- Sits between the per-core request drivers and the memory port.
- Supports locked bursts, so one core can hold the port for up to MAX_BURST consecutive accepts.
- Tracks the core ID of every outstanding request in order, so each memory response goes back to the core that issued it.

---
 rtl/mp_mem_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_mp_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mp_mem_arbiter.sv
// mp_mem_arbiter: four-core round-robin arbiter that shares the single request
// port of the shared memory between all cores.
//
// Supports locked bursts: a core that asserts c_lock keeps the port for up to
// MAX_BURST consecutive accepts. The core ID of every accepted request is kept
// in an in-order FIFO, so each memory response is routed back to its issuer.
//
// Ports
//   clk, rst               clock (rising edge), asynchronous active-high reset
//   c_req/c_lock/c_we      per-core request, burst lock, write enable
//   c_addr/c_wdata         per-core address / write data, core i at [i*W +: W]
//   c_gnt                  one-hot: request of core i accepted this cycle
//   c_rvalid/c_rdata       one-hot response strobe / response data
//   m_req/m_gnt            memory request / memory accept
//   m_we/m_addr/m_wdata    request fields of the selected core (0 when idle)
//   m_core_id              ID of the selected core
//   m_rvalid/m_rdata       memory response strobe / data
//   busy                   outstanding-ID FIFO not empty
//   err_unexp              sticky: response arrived with no request outstanding
module mp_mem_arbiter #(
  parameter int unsigned NCORE     = 4,
  parameter int unsigned AW        = 11,
  parameter int unsigned DW        = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned ID_DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NCORE-1:0]         c_req,
  input  logic [NCORE-1:0]         c_lock,
  input  logic [NCORE-1:0]         c_we,
  input  logic [NCORE*AW-1:0]      c_addr,
  input  logic [NCORE*DW-1:0]      c_wdata,
  output logic [NCORE-1:0]         c_gnt,
  output logic [NCORE-1:0]         c_rvalid,
  output logic [DW-1:0]            c_rdata,
  output logic                     m_req,
  input  logic                     m_gnt,
  output logic                     m_we,
  output logic [AW-1:0]            m_addr,
  output logic [DW-1:0]            m_wdata,
  output logic [$clog2(NCORE)-1:0] m_core_id,
  input  logic                     m_rvalid,
  input  logic [DW-1:0]            m_rdata,
  output logic                     busy,
  output logic                     err_unexp
);

  localparam int unsigned IW = $clog2(NCORE);
  localparam int unsigned PW = $clog2(ID_DEPTH);
  localparam int unsigned CW = $clog2(ID_DEPTH + 1);
  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_ARB    = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [BW-1:0] beat_cnt_q, beat_cnt_d;

  logic [IW-1:0] id_mem [ID_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          err_q;

  logic [IW-1:0] arb_sel, idx, sel, head;
  logic          arb_found, eligible;
  logic          fifo_full, fifo_empty;
  logic          req_int, accept, pop;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  function automatic logic [IW-1:0] next_id(input logic [IW-1:0] id);
    return (int'(id) == NCORE - 1) ? '0 : id + 1'b1;
  endfunction

  // Round-robin search starting at rr_ptr
  always_comb begin
    arb_sel   = '0;
    arb_found = 1'b0;
    idx       = '0;
    for (int k = 0; k < NCORE; k++) begin
      idx = IW'((int'(rr_ptr_q) + k) % NCORE);
      if (!arb_found && c_req[idx]) begin
        arb_found = 1'b1;
        arb_sel   = idx;
      end
    end
  end

  assign sel        = (state_q == ST_LOCKED) ? owner_q : arb_sel;
  assign eligible   = (state_q == ST_LOCKED) ? c_req[owner_q] : arb_found;
  assign fifo_full  = (count_q == CW'(ID_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign head       = id_mem[rd_ptr_q];

  // A full FIFO blocks the request even if a pop happens this cycle
  assign req_int = !rst && eligible && !fifo_full;
  assign accept  = req_int && m_gnt;
  assign pop     = !rst && m_rvalid && !fifo_empty;

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NCORE; i++) begin
      if (IW'(i) == sel) begin
        sel_we    = c_we[i];
        sel_addr  = c_addr[i*AW +: AW];
        sel_wdata = c_wdata[i*DW +: DW];
      end
    end
  end

  assign m_req     = req_int;
  assign m_we      = req_int && sel_we;
  assign m_addr    = req_int ? sel_addr : '0;
  assign m_wdata   = req_int ? sel_wdata : '0;
  assign m_core_id = req_int ? sel : '0;
  assign c_gnt     = accept ? (NCORE'(1) << sel) : '0;
  assign c_rvalid  = pop ? (NCORE'(1) << head) : '0;
  assign c_rdata   = pop ? m_rdata : '0;
  assign busy      = !rst && !fifo_empty;
  assign err_unexp = err_q;

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ST_ARB: begin
        if (accept) begin
          if (c_lock[sel] && MAX_BURST > 1) begin
            state_d    = ST_LOCKED;
            owner_d    = sel;
            beat_cnt_d = BW'(1);
          end else begin
            rr_ptr_d = next_id(sel);
          end
        end
      end
      ST_LOCKED: begin
        if (!c_req[owner_q]) begin
          // Owner went away: release without granting this cycle
          state_d    = ST_ARB;
          rr_ptr_d   = next_id(owner_q);
          beat_cnt_d = '0;
        end else if (accept) begin
          if (!c_lock[owner_q] || beat_cnt_q == BW'(MAX_BURST - 1)) begin
            state_d    = ST_ARB;
            rr_ptr_d   = next_id(owner_q);
            beat_cnt_d = '0;
          end else begin
            beat_cnt_d = beat_cnt_q + 1'b1;
          end
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_ARB;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      if (accept) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)    rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !accept) count_q <= count_q - 1'b1;
      if (m_rvalid && fifo_empty) err_q <= 1'b1;
    end
  end

  // Storage only; validity is tracked by the pointers and count
  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr_q] <= sel;
  end

endmodule

// File: tb/tb_mp_mem_arbiter.sv
// Self-checking bench for mp_mem_arbiter: directed scenarios plus randomized
// traffic, all checked against a queue-based reference model and a
// one-cycle-latency memory model kept in the bench.
module tb_mp_mem_arbiter;
  localparam int NCORE = 4;
  localparam int AW    = 11;
  localparam int DW    = 8;
  localparam int MAXB  = 4;
  localparam int DEPTH = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [NCORE-1:0]    c_req, c_lock, c_we;
  logic [NCORE*AW-1:0] c_addr;
  logic [NCORE*DW-1:0] c_wdata;
  logic [NCORE-1:0]    c_gnt, c_rvalid;
  logic [DW-1:0]       c_rdata;
  logic                m_req, m_gnt, m_we;
  logic [AW-1:0]       m_addr;
  logic [DW-1:0]       m_wdata;
  logic [1:0]          m_core_id;
  logic                m_rvalid;
  logic [DW-1:0]       m_rdata;
  logic                busy, err_unexp;

  mp_mem_arbiter #(
    .NCORE(NCORE), .AW(AW), .DW(DW), .MAX_BURST(MAXB), .ID_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .c_req(c_req), .c_lock(c_lock), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .m_req(m_req), .m_gnt(m_gnt), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_core_id(m_core_id), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .busy(busy), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: arbitration state, outstanding IDs, pending memory data
  bit         mdl_locked;
  int         mdl_rr, mdl_owner, mdl_beats;
  int         id_q[$];
  logic [7:0] resp_q[$];
  bit         mdl_err;
  logic [7:0] mem_arr [2048];

  bit         rv_en, force_rv;
  logic [3:0] last_gnt, last_rv;
  logic [7:0] last_rdata;

  task automatic model_reset();
    mdl_locked = 0; mdl_rr = 0; mdl_owner = 0; mdl_beats = 0;
    id_q.delete(); resp_q.delete(); mdl_err = 0;
  endtask

  task automatic set_core(input int i, input bit we, input int addr, input int wd);
    c_we[i]            = we;
    c_addr[i*AW +: AW] = AW'(addr);
    c_wdata[i*DW +: DW] = DW'(wd);
  endtask

  // Entered at posedge+1 with inputs applied; returns at next posedge+1
  task automatic cycle();
    int         sel, c;
    bit         elig, exp_req, exp_acc, pop, we;
    logic [10:0] a;
    logic [7:0] wd, exp_rdata;
    int         exp_rv;
    exp_rdata = 8'($urandom);
    if (resp_q.size() > 0) exp_rdata = resp_q[0];
    m_rvalid = force_rv || (rv_en && resp_q.size() > 0);
    m_rdata  = exp_rdata;
    elig = 0; sel = 0;
    if (mdl_locked) begin
      sel  = mdl_owner;
      elig = c_req[sel];
    end else begin
      for (int k = 0; k < NCORE; k++) begin
        c = (mdl_rr + k) % NCORE;
        if (!elig && c_req[c]) begin elig = 1; sel = c; end
      end
    end
    exp_req = elig && (id_q.size() < DEPTH);
    exp_acc = exp_req && m_gnt;
    pop     = m_rvalid && (id_q.size() > 0);
    exp_rv  = pop ? (1 << id_q[0]) : 0;
    a  = c_addr[sel*AW +: AW];
    wd = c_wdata[sel*DW +: DW];
    we = c_we[sel];
    #4;
    check("m_req", 32'(m_req), 32'(exp_req));
    check("c_gnt", 32'(c_gnt), exp_acc ? (1 << sel) : 0);
    check("m_core_id", 32'(m_core_id), exp_req ? sel : 0);
    check("m_addr", 32'(m_addr), exp_req ? 32'(a) : 0);
    check("m_we", 32'(m_we), 32'(exp_req && we));
    check("m_wdata", 32'(m_wdata), exp_req ? 32'(wd) : 0);
    check("c_rvalid", 32'(c_rvalid), exp_rv);
    if (pop) check("c_rdata", 32'(c_rdata), 32'(exp_rdata));
    check("busy", 32'(busy), 32'(id_q.size() > 0));
    check("err_unexp", 32'(err_unexp), 32'(mdl_err));
    last_gnt = c_gnt; last_rv = c_rvalid; last_rdata = c_rdata;
    @(posedge clk);
    if (pop) begin
      void'(id_q.pop_front());
      void'(resp_q.pop_front());
    end else if (m_rvalid) begin
      mdl_err = 1;
    end
    if (exp_acc) begin
      id_q.push_back(sel);
      if (we) begin mem_arr[a] = wd; resp_q.push_back(wd); end
      else resp_q.push_back(mem_arr[a]);
    end
    if (mdl_locked) begin
      if (!c_req[mdl_owner]) begin
        mdl_locked = 0; mdl_rr = (mdl_owner + 1) % NCORE;
      end else if (exp_acc) begin
        if (!c_lock[mdl_owner] || mdl_beats + 1 == MAXB) begin
          mdl_locked = 0; mdl_rr = (mdl_owner + 1) % NCORE;
        end else begin
          mdl_beats++;
        end
      end
    end else if (exp_acc) begin
      if (c_lock[sel] && MAXB > 1) begin
        mdl_locked = 1; mdl_owner = sel; mdl_beats = 1;
      end else begin
        mdl_rr = (sel + 1) % NCORE;
      end
    end
    #1;
  endtask

  // Asserts reset without touching the current inputs, so gating is visible
  task automatic reset_now(input string tag);
    rst = 1'b1;
    #1;
    check({tag, ".m_req"}, 32'(m_req), 0);
    check({tag, ".c_gnt"}, 32'(c_gnt), 0);
    check({tag, ".c_rvalid"}, 32'(c_rvalid), 0);
    check({tag, ".c_rdata"}, 32'(c_rdata), 0);
    check({tag, ".m_addr"}, 32'({m_we, m_addr, m_wdata, m_core_id}), 0);
    check({tag, ".busy"}, 32'(busy), 0);
    check({tag, ".err_unexp"}, 32'(err_unexp), 0);
    c_req = '0; c_lock = '0; force_rv = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic expect_grants(input string tag, input int n, input logic [3:0] seq [8]);
    for (int i = 0; i < n; i++) begin
      cycle();
      check(tag, 32'(last_gnt), 32'(seq[i]));
    end
  endtask

  int         n_acc;
  logic [3:0] seq [8];

  initial begin
    for (int i = 0; i < 2048; i++) mem_arr[i] = '0;
    c_req = '0; c_lock = '0; c_we = '0; c_addr = '0; c_wdata = '0;
    m_gnt = 1'b1; m_rvalid = 1'b0; m_rdata = '0;
    rv_en = 1; force_rv = 0;
    model_reset();
    @(posedge clk);
    #1;
    reset_now("rst0");

    // Idle
    for (int i = 0; i < 3; i++) cycle();

    // Round robin, no lock, memory always grants
    c_req = 4'b1111;
    for (int i = 0; i < 4; i++) set_core(i, 0, 16 + i, 0);
    for (int i = 0; i < 12; i++) begin
      cycle();
      check("rr_order", 32'(last_gnt), 32'(1 << (i % 4)));
    end
    c_req = '0;
    cycle();
    check("rr_last_rv", 32'(last_rv), 32'b1000);

    // Core 2 writes 0xA5 to 0x005, core 1 reads it back
    c_req = 4'b0100; set_core(2, 1, 5, 8'hA5);
    cycle();
    c_req = 4'b0010; set_core(1, 0, 5, 0);
    cycle();
    c_req = 4'b0000;
    cycle();
    check("rd_rvalid", 32'(last_rv), 32'b0010);
    check("rd_data", 32'(last_rdata), 32'hA5);

    // Full burst of core 1, then core 3, then core 1 again
    reset_now("rst1");
    c_req = 4'b1010; c_lock = 4'b0010;
    seq = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0010, 4'b0, 4'b0};
    expect_grants("burst", 6, seq);

    // Lock dropped after two beats: the next beat is the last one
    reset_now("rst2");
    c_req = 4'b1010; c_lock = 4'b0010;
    cycle(); check("drop_b1", 32'(last_gnt), 32'b0010);
    cycle(); check("drop_b2", 32'(last_gnt), 32'b0010);
    c_lock = '0;
    cycle(); check("drop_b3", 32'(last_gnt), 32'b0010);
    cycle(); check("drop_next", 32'(last_gnt), 32'b1000);

    // Memory stall, then FIFO fill with responses held back
    reset_now("rst3");
    c_req = 4'b1111; m_gnt = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("stall_gnt", 32'(last_gnt), 0);
    end
    m_gnt = 1'b1; rv_en = 0; n_acc = 0;
    for (int i = 0; i < 7; i++) begin
      cycle();
      if (last_gnt != 0) n_acc++;
    end
    check("full_accepts", 32'(n_acc), 4);
    rv_en = 1;
    cycle();
    check("full_pop_no_gnt", 32'(last_gnt), 0);
    cycle();
    check("after_pop_gnt", 32'(last_gnt), 32'b0001);
    c_req = '0;
    for (int i = 0; i < 6; i++) cycle();

    // Unexpected response with the FIFO empty
    force_rv = 1;
    cycle();
    check("unexp_rv", 32'(last_rv), 0);
    force_rv = 0;
    for (int i = 0; i < 3; i++) cycle();

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      c_req  = 4'($urandom);
      c_lock = 4'($urandom) & 4'($urandom);
      for (int k = 0; k < NCORE; k++)
        set_core(k, 1'($urandom), $urandom_range(0, 15), $urandom_range(0, 255));
      m_gnt = ($urandom_range(0, 99) < 80);
      rv_en = ($urandom_range(0, 99) < 75);
      cycle();
    end
    check("err_sticky", 32'(err_unexp), 1);

    // Reset in the middle of a locked burst
    m_gnt = 1'b1; rv_en = 1;
    c_req = 4'b1111; c_lock = 4'b1111;
    cycle();
    cycle();
    c_req = 4'b1111; c_lock = 4'b1111;
    reset_now("rst_mid");
    c_req = 4'b1111; c_lock = '0;
    cycle();
    check("post_rst_gnt", 32'(last_gnt), 32'b0001);
    cycle();
    check("post_rst_gnt2", 32'(last_gnt), 32'b0010);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule
